// File: rtl/matrix_stream_scheduler.sv
// Arbitrates two element streams into a matrix assembler, one whole matrix per grant,
// and tracks the two ping-pong result banks the assembler output lands in.

module matrix_stream_bank (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic src_in,
  input  logic rel,
  output logic full,
  output logic src
);
  // A bank is only set while empty, so set and rel never compete for the same bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      src  <= 1'b0;
    end else if (set) begin
      full <= 1'b1;
      src  <= src_in;
    end else if (rel) begin
      full <= 1'b0;
    end
  end
endmodule

module matrix_stream_scheduler #(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           s_valid,
  input  logic [1:0][BITS-1:0] s_data,
  output logic [1:0]           s_ready,
  output logic                 dp_valid,
  output logic [BITS-1:0]      dp_data,
  output logic                 dp_bank,
  input  logic                 dp_done,
  output logic [1:0]           bank_full,
  output logic [1:0]           bank_src,
  input  logic [1:0]           bank_release,
  output logic [15:0]          mat_count
);
  localparam int ELEMENTS = R * C;
  localparam int CW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic            grant;
  logic            pick;
  logic            xfer;
  logic            last_elem;
  logic            done_evt;
  logic [CW-1:0]   count;

  // grant doubles as the round-robin pointer; reset value 1 gives requester 0 priority.
  assign pick      = s_valid[~grant] ? ~grant : grant;
  assign xfer      = s_valid[grant] & s_ready[grant];
  assign last_elem = (count == CW'(ELEMENTS - 1));
  assign done_evt  = (state == WAIT_DONE) && dp_done;
  assign dp_valid  = xfer;
  assign dp_data   = xfer ? s_data[grant] : '0;

  always_comb begin
    state_nxt = state;
    s_ready   = 2'b00;
    case (state)
      IDLE: begin
        if (!bank_full[dp_bank] && (|s_valid)) state_nxt = STREAM;
      end
      STREAM: begin
        s_ready[grant] = 1'b1;
        if (xfer && last_elem) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b1;
      count     <= '0;
      dp_bank   <= 1'b0;
      mat_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == STREAM) grant <= pick;
      if (xfer) count <= last_elem ? '0 : count + CW'(1);
      if (done_evt) begin
        dp_bank   <= ~dp_bank;
        mat_count <= mat_count + 16'd1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_stream_bank u_bank (
      .clk    (clk),
      .reset  (reset),
      .set    (done_evt && (dp_bank == 1'(b))),
      .src_in (grant),
      .rel    (bank_release[b]),
      .full   (bank_full[b]),
      .src    (bank_src[b])
    );
  end
endmodule

// File: tb/tb_matrix_stream_scheduler.sv
// Directed bench for matrix_stream_scheduler at R=C=3, BITS=8.

module tb_matrix_stream_scheduler;
  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      s_valid;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_ready;
  logic            dp_valid;
  logic [7:0]      dp_data;
  logic            dp_bank;
  logic            dp_done;
  logic [1:0]      bank_full;
  logic [1:0]      bank_src;
  logic [1:0]      bank_release;
  logic [15:0]     mat_count;

  int nerr = 0;
  int nchk = 0;

  logic [7:0] got [16];
  int         got_n, foreign, dirty, first_cyc, last_cyc;
  logic [1:0] wd_ready;

  matrix_stream_scheduler #(.BITS(8), .R(3), .C(3)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_bank(dp_bank), .dp_done(dp_done),
    .bank_full(bank_full), .bank_src(bank_src), .bank_release(bank_release),
    .mat_count(mat_count)
  );

  always #5 clk = ~clk;

  // Drives requester r for n accepted elements, recording what the datapath saw.
  task automatic stream(input int r, input logic [7:0] base, input int n, input bit gaps,
                        input bit both, input logic [1:0] rel);
    logic [1:0] own;
    own = 2'b01 << r;
    got_n = 0; foreign = 0; dirty = 0; first_cyc = -1; last_cyc = -1;
    bank_release = rel;
    s_valid[r] = 1'b1; s_data[r] = base;
    s_valid[1-r] = both; s_data[1-r] = 8'hEE;
    #1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (dp_valid) begin
        if (got_n < 16) got[got_n] = dp_data;
        got_n++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (s_ready !== own) foreign++;
      end else if (dp_data !== 8'h00) dirty++;
      if (got_n >= n) break;
      @(posedge clk); #1;
      bank_release = 2'b00;
      s_data[r] = base + 8'(got_n);
      if (gaps) s_valid[r] = ~s_valid[r];
      @(negedge clk);
    end
  endtask

  // Lets the last element land, samples s_ready in WAIT_DONE, then pulses dp_done.
  task automatic finish(input bit both);
    @(posedge clk); #1;
    if (!both) s_valid = 2'b00;
    @(negedge clk);
    wd_ready = s_ready;
    dp_done = 1'b1;
    @(posedge clk); #1;
    dp_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 2'b00; dp_done = 1'b0; bank_release = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 2'b11; s_data = {8'h55, 8'hAA}; dp_done = 1'b0; bank_release = 2'b00;
    #2;
    nchk++; if (s_ready !== 2'b00) begin nerr++; $display("FAIL reset_s_ready: got %b want 00", s_ready); end
    nchk++; if (dp_valid !== 1'b0) begin nerr++; $display("FAIL reset_dp_valid: got %b want 0", dp_valid); end
    nchk++; if (dp_data !== 8'h00) begin nerr++; $display("FAIL reset_dp_data: got %h want 00", dp_data); end
    nchk++; if (dp_bank !== 1'b0) begin nerr++; $display("FAIL reset_dp_bank: got %b want 0", dp_bank); end
    nchk++; if (bank_full !== 2'b00) begin nerr++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
    nchk++; if (bank_src !== 2'b00) begin nerr++; $display("FAIL reset_bank_src: got %b want 00", bank_src); end
    nchk++; if (mat_count !== 16'd0) begin nerr++; $display("FAIL reset_mat_count: got %0d want 0", mat_count); end
    s_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int bad;
    stream(0, 8'h01, 9, 1'b0, 1'b0, 2'b00);
    bad = 0;
    for (int i = 0; i < 9; i++) if (got[i] !== 8'(i + 1)) bad++;
    nchk++; if (got_n !== 9) begin nerr++; $display("FAIL single_count: got %0d want 9", got_n); end
    nchk++; if (bad !== 0) begin nerr++; $display("FAIL single_data: got %0d bad want 0", bad); end
    nchk++; if (last_cyc - first_cyc !== 8) begin nerr++; $display("FAIL single_span: got %0d want 8", last_cyc - first_cyc); end
    finish(1'b0);
    nchk++; if (wd_ready !== 2'b00) begin nerr++; $display("FAIL single_wait_ready: got %b want 00", wd_ready); end
    nchk++; if (bank_full !== 2'b01) begin nerr++; $display("FAIL single_bank_full: got %b want 01", bank_full); end
    nchk++; if (bank_src[0] !== 1'b0) begin nerr++; $display("FAIL single_bank_src: got %b want 0", bank_src[0]); end
    nchk++; if (dp_bank !== 1'b1) begin nerr++; $display("FAIL single_dp_bank: got %b want 1", dp_bank); end
    nchk++; if (mat_count !== 16'd1) begin nerr++; $display("FAIL single_mat_count: got %0d want 1", mat_count); end
    bank_release = 2'b11;
    @(posedge clk); #1;
    bank_release = 2'b00;
    @(negedge clk);
    nchk++; if (bank_full !== 2'b00) begin nerr++; $display("FAIL single_release: got %b want 00", bank_full); end
  endtask

  task automatic test_done_ignored();
    int bad;
    dp_done = 1'b1;
    @(posedge clk); #1;
    dp_done = 1'b0;
    @(negedge clk);
    nchk++; if ({mat_count, bank_full} !== {16'd1, 2'b00}) begin nerr++; $display("FAIL idle_done: got %0d/%b want 1/00", mat_count, bank_full); end
    s_valid = 2'b10; s_data[1] = 8'h20;
    @(negedge clk);
    nchk++; if ({dp_valid, dp_data} !== {1'b1, 8'h20}) begin nerr++; $display("FAIL stream_first: got %b/%h want 1/20", dp_valid, dp_data); end
    dp_done = 1'b1;
    @(posedge clk); #1;
    dp_done = 1'b0; s_valid = 2'b00;
    @(negedge clk);
    nchk++; if (s_ready !== 2'b10) begin nerr++; $display("FAIL stream_done_state: got %b want 10", s_ready); end
    nchk++; if ({mat_count, bank_full} !== {16'd1, 2'b00}) begin nerr++; $display("FAIL stream_done: got %0d/%b want 1/00", mat_count, bank_full); end
    stream(1, 8'h21, 8, 1'b0, 1'b0, 2'b00);
    bad = 0;
    for (int i = 0; i < 8; i++) if (got[i] !== 8'(8'h21 + i)) bad++;
    nchk++; if (got_n !== 8 || bad !== 0) begin nerr++; $display("FAIL req1_data: got %0d elems %0d bad want 8/0", got_n, bad); end
    finish(1'b0);
    nchk++; if (wd_ready !== 2'b00) begin nerr++; $display("FAIL req1_wait_ready: got %b want 00", wd_ready); end
    nchk++; if ({bank_full, bank_src} !== 4'b1010) begin nerr++; $display("FAIL req1_banks: got %b/%b want 10/10", bank_full, bank_src); end
    nchk++; if ({mat_count, dp_bank} !== {16'd2, 1'b0}) begin nerr++; $display("FAIL req1_count: got %0d/%b want 2/0", mat_count, dp_bank); end
  endtask

  task automatic test_gaps();
    int bad;
    stream(0, 8'h40, 9, 1'b1, 1'b0, 2'b10);
    bad = 0;
    for (int i = 0; i < 9; i++) if (got[i] !== 8'(8'h40 + i)) bad++;
    nchk++; if (got_n !== 9 || bad !== 0) begin nerr++; $display("FAIL gaps_data: got %0d elems %0d bad want 9/0", got_n, bad); end
    nchk++; if (last_cyc - first_cyc !== 16) begin nerr++; $display("FAIL gaps_span: got %0d want 16", last_cyc - first_cyc); end
    nchk++; if (dirty !== 0) begin nerr++; $display("FAIL gaps_idle_data: got %0d nonzero want 0", dirty); end
    finish(1'b0);
    nchk++; if (wd_ready !== 2'b00) begin nerr++; $display("FAIL gaps_wait_ready: got %b want 00", wd_ready); end
    nchk++; if ({bank_full, mat_count} !== {2'b01, 16'd3}) begin nerr++; $display("FAIL gaps_done: got %b/%0d want 01/3", bank_full, mat_count); end
  endtask

  task automatic test_round_robin();
    int bad;
    logic [1:0] rel;
    logic [7:0] base;
    do_reset();
    for (int m = 0; m < 4; m++) begin
      rel = (m == 0) ? 2'b00 : (2'b01 << ((m - 1) % 2));
      base = 8'h10 + 8'(m * 16);
      stream(m % 2, base, 9, 1'b0, 1'b1, rel);
      bad = 0;
      for (int i = 0; i < 9; i++) if (got[i] !== base + 8'(i)) bad++;
      nchk++; if (got_n !== 9) begin nerr++; $display("FAIL rr_count m%0d: got %0d want 9", m, got_n); end
      nchk++; if (bad !== 0) begin nerr++; $display("FAIL rr_data m%0d: got %0d bad want 0", m, bad); end
      nchk++; if (foreign !== 0) begin nerr++; $display("FAIL rr_grant m%0d: got %0d foreign want 0", m, foreign); end
      finish(1'b1);
    end
    s_valid = 2'b00;
    nchk++; if ({bank_full, bank_src[1]} !== 3'b101) begin nerr++; $display("FAIL rr_banks: got %b/%b want 10/1", bank_full, bank_src[1]); end
    nchk++; if (mat_count !== 16'd4) begin nerr++; $display("FAIL rr_mat_count: got %0d want 4", mat_count); end
  endtask

  task automatic test_back_to_back_full();
    int bad;
    do_reset();
    stream(0, 8'h60, 9, 1'b0, 1'b0, 2'b00);
    finish(1'b0);
    stream(1, 8'h70, 9, 1'b0, 1'b0, 2'b00);
    finish(1'b0);
    nchk++; if ({bank_full, bank_src} !== 4'b1110) begin nerr++; $display("FAIL full_banks: got %b/%b want 11/10", bank_full, bank_src); end
    s_valid = 2'b11;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready !== 2'b00) bad++;
    end
    nchk++; if (bad !== 0) begin nerr++; $display("FAIL full_stall: got %0d ready cycles want 0", bad); end
    stream(0, 8'h80, 9, 1'b0, 1'b0, 2'b01);
    bad = 0;
    for (int i = 0; i < 9; i++) if (got[i] !== 8'(8'h80 + i)) bad++;
    nchk++; if (first_cyc !== 2) begin nerr++; $display("FAIL full_grant_delay: got %0d want 2", first_cyc); end
    nchk++; if (got_n !== 9 || bad !== 0) begin nerr++; $display("FAIL full_third_data: got %0d elems %0d bad want 9/0", got_n, bad); end
    finish(1'b0);
    nchk++; if ({bank_full, bank_src, dp_bank} !== 5'b11101) begin nerr++; $display("FAIL full_third_bank: got %b/%b/%b want 11/10/1", bank_full, bank_src, dp_bank); end
    nchk++; if (mat_count !== 16'd3) begin nerr++; $display("FAIL full_mat_count: got %0d want 3", mat_count); end
  endtask

  task automatic test_reset_mid();
    int bad;
    stream(1, 8'h90, 5, 1'b0, 1'b0, 2'b10);
    nchk++; if (got_n !== 5) begin nerr++; $display("FAIL mid_partial: got %0d want 5", got_n); end
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    nchk++; if (s_ready !== 2'b00) begin nerr++; $display("FAIL mid_s_ready: got %b want 00", s_ready); end
    nchk++; if ({dp_valid, dp_data} !== 9'd0) begin nerr++; $display("FAIL mid_dp: got %b/%h want 0/00", dp_valid, dp_data); end
    nchk++; if ({bank_full, bank_src} !== 4'b0000) begin nerr++; $display("FAIL mid_banks: got %b/%b want 00/00", bank_full, bank_src); end
    nchk++; if ({mat_count, dp_bank} !== 17'd0) begin nerr++; $display("FAIL mid_count: got %0d/%b want 0/0", mat_count, dp_bank); end
    s_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stream(0, 8'hA0, 9, 1'b0, 1'b0, 2'b00);
    bad = 0;
    for (int i = 0; i < 9; i++) if (got[i] !== 8'(8'hA0 + i)) bad++;
    nchk++; if (got_n !== 9 || bad !== 0) begin nerr++; $display("FAIL mid_restart: got %0d elems %0d bad want 9/0", got_n, bad); end
    finish(1'b0);
    nchk++; if (wd_ready !== 2'b00) begin nerr++; $display("FAIL mid_wait_ready: got %b want 00", wd_ready); end
    nchk++; if ({bank_full, bank_src, dp_bank} !== 5'b01001) begin nerr++; $display("FAIL mid_bank: got %b/%b/%b want 01/00/1", bank_full, bank_src, dp_bank); end
    nchk++; if (mat_count !== 16'd1) begin nerr++; $display("FAIL mid_mat_count: got %0d want 1", mat_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_done_ignored();
    test_gaps();
    test_round_robin();
    test_back_to_back_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/matrix_stream_scheduler.md
MATRIX_STREAM_SCHEDULER -- requirements
Module: matrix_stream_scheduler

Interface
REQ-001 SHALL have parameter BITS, default 8: element width.
REQ-002 SHALL have parameter R, default 3: matrix rows.
REQ-003 SHALL have parameter C, default 3: matrix columns; ELEMENTS = R*C.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port s_valid, input, 2 bits: per-requester element valid.
REQ-007 SHALL have port s_data, input, 2 x BITS: per-requester element data.
REQ-008 SHALL have port s_ready, output, 2 bits: per-requester accept.
REQ-009 SHALL have port dp_valid, output, 1 bit: element strobe to the matrix assembler (its in_valid).
REQ-010 SHALL have port dp_data, output, BITS bits: element to the assembler (its a).
REQ-011 SHALL have port dp_bank, output, 1 bit: ping-pong bank the assembler output is captured into.
REQ-012 SHALL have port dp_done, input, 1 bit: assembler out_valid pulse.
REQ-013 SHALL have port bank_full, output, 2 bits: bank holds a complete, unconsumed matrix.
REQ-014 SHALL have port bank_src, output, 2 bits: bit b = requester that filled bank b.
REQ-015 SHALL have port bank_release, input, 2 bits: consumer frees bank b.
REQ-016 SHALL have port mat_count, output, 16 bits: completed matrices, wraps modulo 2^16.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, WAIT_DONE.
REQ-018 IDLE -> STREAM SHALL occur when bank_full[dp_bank]=0 and any s_valid=1; the grant is latched on that edge.
REQ-019 Arbitration SHALL be round-robin per whole matrix: the last granted requester has lower priority; after reset, requester 0 has priority.
REQ-020 Grant SHALL be held for exactly ELEMENTS accepted elements; it is never preempted mid-matrix.
REQ-021 s_ready[g] SHALL be 1 only in STREAM for the granted g; the other bit SHALL be 0.
REQ-022 Transfer = s_valid[g] & s_ready[g], combinational: dp_valid = transfer and dp_data = s_data[g], zero latency.
REQ-023 dp_data SHALL be 0 whenever dp_valid=0.
REQ-024 Element counter SHALL run 0..ELEMENTS-1, increment only on transfer, and idle cycles (s_valid=0) SHALL NOT advance it.
REQ-025 Transfer at count ELEMENTS-1 SHALL clear the counter and go to WAIT_DONE.
REQ-026 In WAIT_DONE, s_ready SHALL be 00; on dp_done, set bank_full[dp_bank], set bank_src[dp_bank]=g, increment mat_count, toggle dp_bank, go to IDLE.
REQ-027 dp_done outside WAIT_DONE SHALL be ignored.
REQ-028 bank_release[b]=1 SHALL clear bank_full[b] on the next edge; release of an empty bank has no effect.
REQ-029 Release of the bank being set in the same cycle cannot occur (set only when empty); release of the other bank in that cycle SHALL take effect.
REQ-030 With both banks full, FSM SHALL stay in IDLE with s_ready=00 until the bank at dp_bank is released.
REQ-031 Release and IDLE->STREAM SHALL NOT combine in one cycle: the cleared bank is seen full until the following edge.

Reset
REQ-032 On reset, whatever the state, the FSM SHALL go to IDLE immediately, including mid-matrix or WAIT_DONE.
REQ-033 On reset, count=0, dp_bank=0, bank_full=00, bank_src=00, mat_count=0, and round-robin pointer favours requester 0.
REQ-034 Reset SHALL force s_ready=00 and dp_valid=0 while asserted; a partial matrix is discarded.

Verification (R=C=3, BITS=8)
REQ-035 Requester 0 streams 1..9 back-to-back with dp_done one cycle after the ninth element -> dp_valid for 9 cycles with dp_data 1..9, bank_full=01, bank_src[0]=0, dp_bank=1, mat_count=1.
REQ-036 Both requesters are valid continuously with the consumer releasing every bank -> grants alternate 0,1,0,1 per 9-element matrix; no element of the non-granted requester is accepted.
REQ-037 Two matrices are sent with no release -> bank_full=11 and s_ready stays 00 for 20 cycles; releasing bank 0 -> the third matrix is granted two edges later and fills bank 0.
REQ-038 s_valid toggles 1,0,1,0 during a matrix -> the counter advances only on accepted elements, and WAIT_DONE is entered after the ninth accepted element.
REQ-039 Reset is asserted after 5 elements -> outputs reach the reset values without a clock edge; the next matrix starts at count 0 into bank 0.
REQ-040 dp_done is pulsed in IDLE and in STREAM -> no change to bank_full or mat_count.
